// File: rtl/out_data_misr_if.sv
// out_data_misr_if: handshake/data bundle between the word source and the MISR stage.
// Ports: start/clr control, in_valid/in_data word stream, sig_valid/sig_ready/sig_data result,
//        busy/word_cnt/drop_cnt status and probe_data live MISR view.
interface out_data_misr_if #(
  parameter int WORD_W = 96,
  parameter int SIG_W  = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              clr;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              sig_valid;
  logic              sig_ready;
  logic [SIG_W-1:0]  sig_data;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        drop_cnt;
  logic [SIG_W-1:0]  probe_data;

  // Word source / signature consumer side.
  modport master (
    output start, clr, in_valid, in_data, sig_ready,
    input  sig_valid, sig_data, busy, word_cnt, drop_cnt, probe_data
  );

  // MISR stage side.
  modport slave (
    input  start, clr, in_valid, in_data, sig_ready,
    output sig_valid, sig_data, busy, word_cnt, drop_cnt, probe_data
  );
endinterface

// File: rtl/out_data_misr.sv
// out_data_misr: folds WIN_LEN qualified words into a SIG_W-bit MISR and offers the signature.
// Latency: signature valid on the edge after the last accepted word; sig_valid drops the edge after acceptance.
// Backpressure: DONE holds sig_data/MISR frozen until sig_ready; words arriving meanwhile only bump drop_cnt.
// Ports: clkin_data (clock), rstn_data (async active-low reset), bus (out_data_misr_if.slave).
module out_data_misr #(
  parameter int               WORD_W  = 96,
  parameter int               SIG_W   = 32,
  parameter int               WIN_LEN = 16,
  parameter int               CNT_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED    = 32'hFFFFFFFF
) (
  input  logic         clkin_data,
  input  logic         rstn_data,
  out_data_misr_if.slave bus
);

  localparam int               N_SLICE  = WORD_W / SIG_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SIG_W-1:0] r_misr;
  logic [SIG_W-1:0] r_sig_data;
  logic [CNT_W-1:0] r_word_cnt;
  logic [7:0]       r_drop_cnt;
  logic [SIG_W-1:0] w_fold;
  logic [SIG_W-1:0] w_misr_nxt;
  logic             w_accept;
  logic             w_last;

  // Compress the wide word to one signature-width value before it enters the MISR.
  always_comb begin
    w_fold = '0;
    for (int k = 0; k < N_SLICE; k++) begin
      w_fold = w_fold ^ bus.in_data[k*SIG_W +: SIG_W];
    end
  end

  // Galois-style step: shift, reduce by POLY when the MSB falls out, then inject the folded word.
  assign w_misr_nxt = {r_misr[SIG_W-2:0], 1'b0} ^ (r_misr[SIG_W-1] ? POLY : '0) ^ w_fold;

  assign w_accept = (r_state == ST_RUN) && bus.in_valid;
  assign w_last   = w_accept && (r_word_cnt == LAST_IDX);

  always_ff @(posedge clkin_data or negedge rstn_data) begin
    if (!rstn_data) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start)     w_state_nxt = ST_RUN;
        ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
        ST_DONE: if (bus.sig_ready) w_state_nxt = ST_IDLE;
        default:                    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin_data or negedge rstn_data) begin
    if (!rstn_data) begin
      r_misr     <= SEED;
      r_word_cnt <= '0;
      r_sig_data <= '0;
    end else if (bus.clr) begin
      // Abort keeps the last signature visible; only the accumulation restarts.
      r_misr     <= SEED;
      r_word_cnt <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_misr     <= SEED;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_misr     <= w_misr_nxt;
      r_word_cnt <= r_word_cnt + CNT_W'(1);
      if (w_last) begin
        r_sig_data <= w_misr_nxt;
      end
    end
  end

  // Words offered while the signature waits are lost; count them so the harness can tell.
  always_ff @(posedge clkin_data or negedge rstn_data) begin
    if (!rstn_data) begin
      r_drop_cnt <= '0;
    end else if (!bus.clr && (r_state == ST_DONE) && bus.in_valid && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign bus.sig_valid  = (r_state == ST_DONE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.sig_data   = r_sig_data;
  assign bus.word_cnt   = r_word_cnt;
  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.probe_data = r_misr;

endmodule

// File: tb/tb_out_data_misr.sv
// tb_out_data_misr: randomized scoreboard bench for out_data_misr.
// Instance A uses a 4-word window, instance B a 1-word window; both share clock and reset.
// Expected signatures are queued at stimulus time and popped by monitors on each handshake.
module tb_out_data_misr;

  localparam logic [31:0] SEED = 32'hFFFFFFFF;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam int          WA   = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  out_data_misr_if #(.WORD_W(96), .SIG_W(32), .CNT_W(16)) ifa ();
  out_data_misr_if #(.WORD_W(96), .SIG_W(32), .CNT_W(16)) ifb ();

  out_data_misr #(.WIN_LEN(WA)) dut_a (.clkin_data(clk), .rstn_data(rstn), .bus(ifa.slave));
  out_data_misr #(.WIN_LEN(1))  dut_b (.clkin_data(clk), .rstn_data(rstn), .bus(ifb.slave));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [95:0] wdat[WA];

  // Signature arithmetic: multiply the running remainder by x modulo POLY, then add the
  // XOR of the three 32-bit slices of the word.
  function automatic logic [31:0] model_step(input logic [31:0] m, input logic [95:0] d);
    logic [31:0] f;
    logic [32:0] t;
    f = d[31:0] ^ d[63:32] ^ d[95:64];
    t = {m, 1'b0};
    if (t[32]) t[31:0] = t[31:0] ^ POLY;
    return t[31:0] ^ f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one window on instance A. vpat selects valid cycles (0 = random), fixed uses wdat[].
  // With hold_done the task returns in DONE without completing the handshake.
  task automatic run_window_a(input logic [31:0] vpat, input bit fixed, input bit hold_done,
                              output logic [31:0] sig);
    logic [31:0] m;
    logic [95:0] d;
    int          c;
    int          cyc;
    bit          v;
    m   = SEED;
    c   = 0;
    cyc = 0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("a_busy_after_start", ifa.busy, 1);
    chk("a_probe_seed_start", ifa.probe_data, SEED);
    chk("a_cnt_clear_start", ifa.word_cnt, 0);
    while (c < WA && cyc < 64) begin
      v = (vpat != 0) ? vpat[cyc] : ($urandom_range(0, 1) == 1);
      d = fixed ? wdat[c] : {$urandom, $urandom, $urandom};
      ifa.in_valid = v;
      ifa.in_data  = d;
      if (v) begin
        m = model_step(m, d);
        c++;
        if (c == WA) qa.push_back(m);
      end
      tick();
      cyc++;
      if (c < WA) begin
        chk("a_word_cnt", ifa.word_cnt, c);
        chk("a_probe_run", ifa.probe_data, m);
        chk("a_no_early_valid", ifa.sig_valid, 0);
      end
    end
    ifa.in_valid = 1'b0;
    if (c < WA) chk("a_window_timeout", c, WA);
    chk("a_sig_valid_rise", ifa.sig_valid, 1);
    chk("a_probe_done", ifa.probe_data, m);
    chk("a_word_cnt_done", ifa.word_cnt, WA);
    sig = m;
    if (!hold_done) begin
      repeat ($urandom_range(0, 3)) begin
        ifa.sig_ready = 1'b0;
        tick();
        chk("a_sig_valid_hold", ifa.sig_valid, 1);
        chk("a_sig_data_hold", ifa.sig_data, m);
      end
      ifa.sig_ready = 1'b1;
      tick();
      chk("a_idle_after_hs", ifa.busy, 0);
      chk("a_valid_drop_after_hs", ifa.sig_valid, 0);
    end
  endtask

  // Scoreboard monitors: compare at every completed handshake, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rstn && ifa.sig_valid && ifa.sig_ready) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_sig_unexpected at %0t: got %0h expected none", $time, ifa.sig_data);
      end else begin
        chk("a_sig_data", ifa.sig_data, qa.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn && ifb.sig_valid && ifb.sig_ready) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_sig_unexpected at %0t: got %0h expected none", $time, ifb.sig_data);
      end else begin
        chk("b_sig_data", ifb.sig_data, qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s;
    logic [31:0] s2;
    logic [9:0]  bp;
    ifa.start = 0; ifa.clr = 0; ifa.in_valid = 0; ifa.in_data = '0; ifa.sig_ready = 1;
    ifb.start = 0; ifb.clr = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.sig_ready = 1;
    for (int i = 0; i < WA; i++) wdat[i] = {$urandom, $urandom, $urandom};

    // Reset state
    repeat (2) tick();
    chk("rst_a_probe", ifa.probe_data, SEED);
    chk("rst_a_word_cnt", ifa.word_cnt, 0);
    chk("rst_a_drop_cnt", ifa.drop_cnt, 0);
    chk("rst_a_sig_data", ifa.sig_data, 0);
    chk("rst_a_sig_valid", ifa.sig_valid, 0);
    chk("rst_a_busy", ifa.busy, 0);
    chk("rst_b_probe", ifb.probe_data, SEED);
    chk("rst_b_sig_data", ifb.sig_data, 0);
    rstn = 1'b1;
    tick();

    // One-word window: zero word, then equal slices folding to 1
    ifb.start = 1; tick(); ifb.start = 0;
    ifb.in_valid = 1; ifb.in_data = '0; qb.push_back(32'hFB3EE249);
    tick();
    ifb.in_valid = 0;
    chk("b_zero_valid", ifb.sig_valid, 1);
    tick();
    chk("b_zero_valid_one_cycle", ifb.sig_valid, 0);
    chk("b_zero_idle", ifb.busy, 0);
    ifb.start = 1; tick(); ifb.start = 0;
    ifb.in_valid = 1; ifb.in_data = {32'h1, 32'h1, 32'h1}; qb.push_back(32'hFB3EE248);
    tick();
    ifb.in_valid = 0;
    chk("b_fold_valid", ifb.sig_valid, 1);
    tick();
    chk("b_fold_valid_one_cycle", ifb.sig_valid, 0);

    // Gapped window: valid on RUN cycles 1, 3, 4, 7
    run_window_a(32'h4D, 1'b1, 1'b0, s);

    // Random windows with random gaps and random consumer stalls
    for (int w = 0; w < 6; w++) run_window_a(32'h0, 1'b0, 1'b0, s);

    // Backpressure: 10 stalled cycles, 6 of them carrying words
    run_window_a(32'h0, 1'b0, 1'b1, s);
    ifa.sig_ready = 1'b0;
    bp = 10'b0101101101;
    for (int i = 0; i < 10; i++) begin
      ifa.in_valid = bp[i];
      ifa.in_data  = {$urandom, $urandom, $urandom};
      tick();
      chk("bp_sig_data", ifa.sig_data, s);
      chk("bp_probe", ifa.probe_data, s);
      chk("bp_sig_valid", ifa.sig_valid, 1);
    end
    ifa.in_valid = 1'b0;
    chk("bp_drop_cnt", ifa.drop_cnt, 6);
    ifa.sig_ready = 1'b1;
    tick();
    chk("bp_idle", ifa.busy, 0);

    // clr together with start in RUN
    ifa.start = 1; tick(); ifa.start = 0;
    repeat (2) begin
      ifa.in_valid = 1; ifa.in_data = {$urandom, $urandom, $urandom};
      tick();
    end
    chk("pri_cnt_before_clr", ifa.word_cnt, 2);
    ifa.clr = 1; ifa.start = 1; ifa.in_valid = 1;
    tick();
    ifa.clr = 0; ifa.start = 0; ifa.in_valid = 0;
    chk("pri_clr_idle", ifa.busy, 0);
    chk("pri_clr_probe", ifa.probe_data, SEED);
    chk("pri_clr_cnt", ifa.word_cnt, 0);
    chk("pri_clr_keep_sig", ifa.sig_data, s);
    tick();
    chk("pri_no_new_window", ifa.busy, 0);

    // start while DONE is ignored
    run_window_a(32'h0, 1'b0, 1'b1, s2);
    ifa.sig_ready = 0; ifa.start = 1;
    tick();
    ifa.start = 0;
    chk("done_start_valid", ifa.sig_valid, 1);
    chk("done_start_busy", ifa.busy, 1);
    chk("done_start_sig", ifa.sig_data, s2);
    ifa.sig_ready = 1;
    tick();
    chk("done_start_idle", ifa.busy, 0);

    // clr while DONE: signature withdrawn but retained, drop_cnt retained
    run_window_a(32'h0, 1'b0, 1'b1, s2);
    ifa.sig_ready = 0; ifa.clr = 1;
    tick();
    ifa.clr = 0;
    void'(qa.pop_back());
    chk("done_clr_valid", ifa.sig_valid, 0);
    chk("done_clr_busy", ifa.busy, 0);
    chk("done_clr_keep_sig", ifa.sig_data, s2);
    chk("done_clr_probe", ifa.probe_data, SEED);
    chk("done_clr_keep_drop", ifa.drop_cnt, 6);
    ifa.sig_ready = 1;
    tick();

    // Reset mid-window after two words, observed before any clock edge
    ifa.start = 1; tick(); ifa.start = 0;
    repeat (2) begin
      ifa.in_valid = 1; ifa.in_data = {$urandom, $urandom, $urandom};
      tick();
    end
    ifa.in_valid = 0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_probe", ifa.probe_data, SEED);
    chk("midrst_cnt", ifa.word_cnt, 0);
    chk("midrst_valid", ifa.sig_valid, 0);
    chk("midrst_busy", ifa.busy, 0);
    chk("midrst_drop", ifa.drop_cnt, 0);
    tick();
    rstn = 1'b1;
    tick();
    run_window_a(32'h4D, 1'b1, 1'b0, s);

    repeat (3) tick();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
